// File: rtl/servo_ramp_sequencer_pkg.sv
// Shared types and constants for the servo ramp sequencer.
package servo_pkg;

  localparam int DUTY_W           = 8;
  localparam int RATE_W           = 4;
  localparam int DEF_FRAME_CYCLES = 1000000;
  localparam int DEF_RESET_DUTY   = 128;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RAMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/servo_ramp_sequencer_if.sv
// Command handshake and servo-controller side of the ramp sequencer.
interface servo_ramp_sequencer_if;
  import servo_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_target;
  logic [RATE_W-1:0] cmd_rate;
  logic              abort;
  logic [DUTY_W-1:0] duty;
  logic              load;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_target, cmd_rate, abort,
    input  cmd_ready, duty, load, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_rate, abort,
    output cmd_ready, duty, load, busy, done
  );

endinterface

// File: rtl/servo_ramp_sequencer_frame_tick_gen.sv
// Free-running frame counter; frame_tick marks the last cycle of each frame.
module frame_tick_gen
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int               CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap back to zero after the last count of the frame.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST_C) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign frame_tick = (cnt_q == LAST_C);

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Ramps a servo duty code toward a commanded target, one rate step per frame,
// strobing load to the servo controller the cycle after every duty update.
module servo_ramp_sequencer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int RESET_DUTY   = DEF_RESET_DUTY
) (
  input  logic                   clock,
  input  logic                   reset_n,
  servo_ramp_sequencer_if.slave  bus
);

  localparam logic [DUTY_W-1:0] RST_DUTY_C = DUTY_W'(RESET_DUTY);

  // Next duty one step toward tgt; lands exactly on tgt when within rate,
  // so the result never wraps past either end of the duty range.
  function automatic logic [DUTY_W-1:0] ramp_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [RATE_W-1:0] rate
  );
    logic signed [DUTY_W:0] diff;
    logic        [DUTY_W:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {{(DUTY_W + 1 - RATE_W){1'b0}}, rate})
      return tgt;
    else if (diff[DUTY_W])
      return cur - {{(DUTY_W - RATE_W){1'b0}}, rate};
    else
      return cur + {{(DUTY_W - RATE_W){1'b0}}, rate};
  endfunction

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic              load_q, load_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              frame_tick;

  frame_tick_gen #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_frame_tick_gen (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick)
  );

  // Next-state, duty update and load scheduling.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    rate_d   = rate_q;
    upd_d    = 1'b0;
    load_d   = upd_q;
    case (state_q)
      ST_INIT: begin
        load_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          target_d = bus.cmd_target;
          rate_d   = bus.cmd_rate;
          if (bus.cmd_rate == '0) begin
            duty_d  = bus.cmd_target;
            upd_d   = 1'b1;
            state_d = ST_DONE;
          end else if (bus.cmd_target == duty_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        // Abort takes priority over a coincident frame tick.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          duty_d = ramp_step(duty_q, target_q, rate_q);
          upd_d  = 1'b1;
          if (duty_d == target_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control and duty registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      duty_q  <= RST_DUTY_C;
      upd_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      upd_q   <= upd_d;
      load_q  <= load_d;
    end
  end

  // Latched command; only meaningful once a handshake has loaded it.
  always_ff @(posedge clock) begin
    target_q <= target_d;
    rate_q   <= rate_d;
  end

  assign bus.duty      = duty_q;
  assign bus.load      = load_q;
  assign bus.busy      = (state_q == ST_RAMP);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Directed bench for servo_ramp_sequencer with a 10-cycle frame.
module tb_servo_ramp_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   passes  = 0;
  int   fails   = 0;
  int   cyc;
  bit   saw_done;
  int   n_load;
  int   n_done;

  servo_ramp_sequencer_if bus ();

  servo_ramp_sequencer #(
    .FRAME_CYCLES (10),
    .RESET_DUTY   (128)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until load is seen (bounded), noting any done pulse on the way.
  task automatic wait_load(output int n, output bit dn);
    n  = 0;
    dn = 1'b0;
    do begin
      step();
      n++;
      if (bus.done) dn = 1'b1;
    end while (!bus.load && n < 40);
  endtask

  task automatic send(input logic [7:0] t, input logic [3:0] r);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = t;
    bus.cmd_rate   = r;
    step();
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 8'd0;
    bus.cmd_rate   = 4'd0;
  endtask

  task automatic jump(input logic [7:0] t, input string tag);
    send(t, 4'd0);
    check({tag, "_duty"}, 32'(bus.duty), 32'(t));
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_noload"}, 32'(bus.load), 0);
    step();
    check({tag, "_load"}, 32'(bus.load), 1);
    check({tag, "_duty_hold"}, 32'(bus.duty), 32'(t));
    step();
    check({tag, "_load_end"}, 32'(bus.load), 0);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 8'd0;
    bus.cmd_rate   = 4'd0;
    bus.abort      = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_duty", 32'(bus.duty), 128);
    check("rst_load", 32'(bus.load), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ready", 32'(bus.cmd_ready), 0);

    // Release: one load pulse at 128, then ready
    reset_n = 1'b1;
    step();
    check("init_load", 32'(bus.load), 1);
    check("init_duty", 32'(bus.duty), 128);
    check("init_ready", 32'(bus.cmd_ready), 1);
    step();
    check("init_load_end", 32'(bus.load), 0);

    // Ramp 128 -> 140 at rate 5; inputs change after the handshake
    send(8'd140, 4'd5);
    check("r1_busy", 32'(bus.busy), 1);
    check("r1_ready", 32'(bus.cmd_ready), 0);
    wait_load(cyc, saw_done);
    check("r1_load1", 32'(bus.load), 1);
    check("r1_duty133", 32'(bus.duty), 133);
    check("r1_nodone1", 32'(saw_done), 0);
    wait_load(cyc, saw_done);
    check("r1_duty138", 32'(bus.duty), 138);
    check("r1_frame_gap", 32'(cyc), 10);
    check("r1_nodone2", 32'(saw_done), 0);
    wait_load(cyc, saw_done);
    check("r1_duty140", 32'(bus.duty), 140);
    check("r1_frame_gap2", 32'(cyc), 10);
    check("r1_done", 32'(saw_done), 1);
    check("r1_idle_ready", 32'(bus.cmd_ready), 1);
    check("r1_idle_busy", 32'(bus.busy), 0);
    step();

    // Immediate jump to 20
    jump(8'd20, "j20");
    check("j20_ready", 32'(bus.cmd_ready), 1);

    // Top boundary: 250 -> 255 at rate 15 without wrapping
    jump(8'd250, "j250");
    send(8'd255, 4'd15);
    wait_load(cyc, saw_done);
    check("top_duty", 32'(bus.duty), 255);
    check("top_done", 32'(saw_done), 1);
    step();

    // Bottom boundary: 5 -> 0 at rate 15
    jump(8'd5, "j5");
    send(8'd0, 4'd15);
    wait_load(cyc, saw_done);
    check("bot_duty", 32'(bus.duty), 0);
    check("bot_done", 32'(saw_done), 1);
    step();

    // Abort alongside a handshake in IDLE does not block the command
    bus.abort = 1'b1;
    jump(8'd128, "jab");
    bus.abort = 1'b0;

    // Abort on the second frame tick of a 128 -> 0 rate-1 ramp
    send(8'd0, 4'd1);
    wait_load(cyc, saw_done);
    check("ab_duty127", 32'(bus.duty), 127);
    repeat (8) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_duty_hold", 32'(bus.duty), 127);
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_ready", 32'(bus.cmd_ready), 1);
    check("ab_done", 32'(bus.done), 0);
    n_load = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.load) n_load++;
      if (bus.done) n_done++;
    end
    check("ab_no_load", 32'(n_load), 0);
    check("ab_no_done", 32'(n_done), 0);
    check("ab_duty_final", 32'(bus.duty), 127);

    // Reset mid-ramp
    send(8'd200, 4'd3);
    wait_load(cyc, saw_done);
    check("mr_duty130", 32'(bus.duty), 130);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("mr_duty", 32'(bus.duty), 128);
    check("mr_busy", 32'(bus.busy), 0);
    check("mr_done", 32'(bus.done), 0);
    check("mr_load", 32'(bus.load), 0);
    check("mr_ready", 32'(bus.cmd_ready), 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    check("mr_init_load", 32'(bus.load), 1);
    check("mr_init_duty", 32'(bus.duty), 128);
    check("mr_init_done", 32'(bus.done), 0);
    check("mr_init_ready", 32'(bus.cmd_ready), 1);
    step();
    check("mr_load_end", 32'(bus.load), 0);
    check("mr_busy_end", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
